// File: rtl/blur_frame_sequencer.sv
// Frame sequencer for the 3x3 Gaussian blur stage.
// Walks the interior windows of an IMG_W x IMG_H image in row-major order. Each window is
// fetched from a 1-cycle-latency read memory, with column reuse when sliding along a row.
// Windows go to the blur datapath as single-cycle strobes. Results are written row-major
// into the (IMG_W-2) x (IMG_H-2) output memory.
module blur_frame_sequencer #(
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [7:0]        rd_data_i,
  output logic [71:0]       win_pixels_o,
  output logic              win_valid_o,
  input  logic              res_valid_i,
  input  logic [7:0]        res_pixel_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o
);

  localparam logic [ADDR_W-1:0] ImgW   = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] LastC  = ADDR_W'(IMG_W - 3);
  localparam logic [ADDR_W-1:0] LastR  = ADDR_W'(IMG_H - 3);
  localparam logic [ADDR_W-1:0] NumOut = ADDR_W'((IMG_W - 2) * (IMG_H - 2));

  typedef enum logic [2:0] {StIdle, StFetch, StWait, StIssue, StDrain} state_e;

  state_e            st_q;
  logic              busy_q;
  logic              done_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              win_valid_q;
  // Window top-left position.
  logic [ADDR_W-1:0] r_q;
  logic [ADDR_W-1:0] c_q;
  // Row/column offset of the read currently on the bus, relative to (r_q, c_q).
  logic [1:0]        fr_q;
  logic [1:0]        fc_q;
  // High in the cycle rd_data_i carries the data of the previous cycle's read.
  logic              cap_q;
  // Window pixels in column-major order: index = col*3 + row.
  logic [7:0]        win_q [9];

  logic [ADDR_W-1:0] wcnt_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;

  logic [1:0]        fr_d;
  logic [1:0]        fc_d;
  logic [ADDR_W-1:0] fetch_addr_d;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [ADDR_W-1:0] row,
                                                input logic [ADDR_W-1:0] col);
    return row * ImgW + col;
  endfunction

  // Next read position inside the fetch: rows first, then the next column.
  always_comb begin
    fr_d = fr_q;
    fc_d = fc_q;
    if (fr_q == 2'd2) begin
      fr_d = 2'd0;
      fc_d = fc_q + 2'd1;
    end else begin
      fr_d = fr_q + 2'd1;
    end
    fetch_addr_d = addr_of(r_q + ADDR_W'(fr_d), c_q + ADDR_W'(fc_d));
  end

  // Frame FSM: window walk, read issue and window strobe, all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= StIdle;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      win_valid_q <= 1'b0;
      r_q         <= '0;
      c_q         <= '0;
      fr_q        <= 2'd0;
      fc_q        <= 2'd0;
    end else begin
      done_q      <= 1'b0;
      win_valid_q <= 1'b0;
      unique case (st_q)
        StIdle: begin
          r_q  <= '0;
          c_q  <= '0;
          fr_q <= 2'd0;
          fc_q <= 2'd0;
          if (start_i) begin
            st_q      <= StFetch;
            busy_q    <= 1'b1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
          end
        end
        StFetch: begin
          if (fr_q == 2'd2 && fc_q == 2'd2) begin
            rd_en_q <= 1'b0;
            st_q    <= StWait;
          end else begin
            fr_q      <= fr_d;
            fc_q      <= fc_d;
            rd_addr_q <= fetch_addr_d;
          end
        end
        StWait: begin
          // The last read's data lands in the window register at this edge.
          st_q        <= StIssue;
          win_valid_q <= 1'b1;
        end
        StIssue: begin
          if (c_q < LastC) begin
            // Slide: only the new right-hand column is fetched.
            c_q       <= c_q + ADDR_W'(1);
            fr_q      <= 2'd0;
            fc_q      <= 2'd2;
            rd_addr_q <= addr_of(r_q, c_q + ADDR_W'(3));
            rd_en_q   <= 1'b1;
            st_q      <= StFetch;
          end else if (r_q < LastR) begin
            r_q       <= r_q + ADDR_W'(1);
            c_q       <= '0;
            fr_q      <= 2'd0;
            fc_q      <= 2'd0;
            rd_addr_q <= addr_of(r_q + ADDR_W'(1), '0);
            rd_en_q   <= 1'b1;
            st_q      <= StFetch;
          end else begin
            st_q <= StDrain;
          end
        end
        StDrain: begin
          if (wcnt_q == NumOut) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            st_q   <= StIdle;
          end
        end
        default: st_q <= StIdle;
      endcase
    end
  end

  // Window shift register: each returned pixel shifts in, so three reads retire one column.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      cap_q <= rd_en_q;
      if (cap_q) begin
        for (int i = 0; i < 8; i++) begin
          win_q[i] <= win_q[i+1];
        end
        win_q[8] <= rd_data_i;
      end
    end
  end

  // Result path: register each blur result as a write to the next output address.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (!busy_q) begin
      wcnt_q  <= '0;
      wr_en_q <= 1'b0;
    end else begin
      wr_en_q <= res_valid_i;
      if (res_valid_i) begin
        wr_data_q <= res_pixel_i;
        wr_addr_q <= wcnt_q;
        wcnt_q    <= wcnt_q + ADDR_W'(1);
      end
    end
  end

  // Present the column-major window register as a row-major 72-bit bus.
  always_comb begin
    win_pixels_o = '0;
    for (int rr = 0; rr < 3; rr++) begin
      for (int cc = 0; cc < 3; cc++) begin
        win_pixels_o[71 - 8 * (rr * 3 + cc) -: 8] = win_q[cc * 3 + rr];
      end
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign rd_en_o     = rd_en_q;
  assign rd_addr_o   = rd_addr_q;
  assign win_valid_o = win_valid_q;
  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;

endmodule

// File: tb/tb_blur_frame_sequencer.sv
// Bench for blur_frame_sequencer: a 4x4 ramp image (pixel = address) and an 8x8 constant-200
// image run side by side on shared clock, reset and start. Expected reads, windows and
// writes (with their cycle numbers) are queued when a frame starts and popped as the DUTs
// produce them.
module tb_blur_frame_sequencer;

  localparam int unsigned AW = 16;

  typedef struct {
    int          cyc;
    int          addr;
    logic [71:0] val;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic poke;

  logic            busy       [2];
  logic            done       [2];
  logic            rd_en      [2];
  logic [AW-1:0]   rd_addr    [2];
  logic [7:0]      rd_data    [2];
  logic [71:0]     win_pixels [2];
  logic            win_valid  [2];
  logic            res_valid  [2];
  logic [7:0]      res_pixel  [2];
  logic            wr_en      [2];
  logic [AW-1:0]   wr_addr    [2];
  logic [7:0]      wr_data    [2];

  logic            pv [2][4];
  logic [7:0]      pd [2][4];

  ev_t q_rd  [2][$];
  ev_t q_win [2][$];
  ev_t q_wr  [2][$];

  int vecs   = 0;
  int misses = 0;

  always #5 clk = ~clk;

  blur_frame_sequencer #(.IMG_W(4), .IMG_H(4), .ADDR_W(AW)) u_dut4 (
    .clk(clk), .rst(rst), .start_i(start), .busy_o(busy[0]), .done_o(done[0]),
    .rd_en_o(rd_en[0]), .rd_addr_o(rd_addr[0]), .rd_data_i(rd_data[0]),
    .win_pixels_o(win_pixels[0]), .win_valid_o(win_valid[0]),
    .res_valid_i(res_valid[0]), .res_pixel_i(res_pixel[0]),
    .wr_en_o(wr_en[0]), .wr_addr_o(wr_addr[0]), .wr_data_o(wr_data[0])
  );

  blur_frame_sequencer #(.IMG_W(8), .IMG_H(8), .ADDR_W(AW)) u_dut8 (
    .clk(clk), .rst(rst), .start_i(start), .busy_o(busy[1]), .done_o(done[1]),
    .rd_en_o(rd_en[1]), .rd_addr_o(rd_addr[1]), .rd_data_i(rd_data[1]),
    .win_pixels_o(win_pixels[1]), .win_valid_o(win_valid[1]),
    .res_valid_i(res_valid[1]), .res_pixel_i(res_pixel[1]),
    .wr_en_o(wr_en[1]), .wr_addr_o(wr_addr[1]), .wr_data_o(wr_data[1])
  );

  function automatic int img_w(input int d);
    return (d == 0) ? 4 : 8;
  endfunction

  function automatic int img_h(input int d);
    return (d == 0) ? 4 : 8;
  endfunction

  function automatic logic [7:0] pix(input int d, input int a);
    if (d == 0) return a[7:0];
    return 8'd200;
  endfunction

  // 1-2-1 / 2-4-2 / 1-2-1 kernel, divided by 16.
  function automatic logic [7:0] gauss(input logic [71:0] w);
    int s;
    int wt;
    s = 0;
    for (int i = 0; i < 9; i++) begin
      wt = (i == 4) ? 4 : ((i % 2) == 1 ? 2 : 1);
      s += wt * int'(w[71 - 8 * i -: 8]);
    end
    return 8'(s >> 4);
  endfunction

  function automatic int done_cyc(input int d);
    return (11 + 5 * (img_w(d) - 3)) * (img_h(d) - 2) + 6;
  endfunction

  // Memories (1-cycle read latency) and 4-cycle blur datapath stubs.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rd_en[d]) rd_data[d] <= pix(d, int'(rd_addr[d]));
      pv[d][0] <= win_valid[d];
      pd[d][0] <= gauss(win_pixels[d]);
      for (int k = 1; k < 4; k++) begin
        pv[d][k] <= pv[d][k-1];
        pd[d][k] <= pd[d][k-1];
      end
    end
  end

  assign res_valid[0] = pv[0][3] | poke;
  assign res_valid[1] = pv[1][3] | poke;
  assign res_pixel[0] = pd[0][3];
  assign res_pixel[1] = pd[1][3];

  task automatic build_expect();
    ev_t         e;
    logic [71:0] w;
    int          wd, ht, rowt, base;
    for (int d = 0; d < 2; d++) begin
      q_rd[d].delete();
      q_win[d].delete();
      q_wr[d].delete();
      wd   = img_w(d);
      ht   = img_h(d);
      rowt = 11 + 5 * (wd - 3);
      for (int r = 0; r <= ht - 3; r++) begin
        for (int c = 0; c <= wd - 3; c++) begin
          base = rowt * r + 1;
          e.val = '0;
          if (c == 0) begin
            for (int k = 0; k < 9; k++) begin
              e.cyc  = base + k;
              e.addr = (r + k % 3) * wd + k / 3;
              q_rd[d].push_back(e);
            end
          end else begin
            for (int rr = 0; rr < 3; rr++) begin
              e.cyc  = base + 6 + 5 * c + rr;
              e.addr = (r + rr) * wd + c + 2;
              q_rd[d].push_back(e);
            end
          end
          for (int rr = 0; rr < 3; rr++) begin
            for (int cc = 0; cc < 3; cc++) begin
              w[71 - 8 * (rr * 3 + cc) -: 8] = pix(d, (r + rr) * wd + c + cc);
            end
          end
          e.cyc  = rowt * r + 11 + 5 * c;
          e.addr = 0;
          e.val  = w;
          q_win[d].push_back(e);
          e.cyc  = e.cyc + 5;
          e.addr = r * (wd - 2) + c;
          e.val  = {64'd0, gauss(w)};
          q_wr[d].push_back(e);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    poke  = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      vecs++;
      if ({busy[d], done[d], rd_en[d], rd_addr[d], win_valid[d], win_pixels[d], wr_en[d],
           wr_addr[d], wr_data[d]} !== '0) begin
        misses++;
        $display("FAIL reset_outputs dut%0d: busy=%b done=%b rd_en=%b rd_addr=%0d win_valid=%b wr_en=%b wr_addr=%0d wr_data=%0d, all required 0",
                 d, busy[d], done[d], rd_en[d], rd_addr[d], win_valid[d], wr_en[d],
                 wr_addr[d], wr_data[d]);
      end
    end
    rst = 1'b0;
  endtask

  // One frame on both DUTs; restart_cyc > 0 re-asserts start in that cycle of the frame.
  task automatic test_frame(input int restart_cyc);
    ev_t e;
    int  dseen [2];
    int  limit;
    build_expect();
    dseen[0] = 0;
    dseen[1] = 0;
    limit    = done_cyc(1) + 8;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      start = (cyc == restart_cyc);
      for (int d = 0; d < 2; d++) begin
        if (cyc == 1) begin
          vecs++;
          if (busy[d] !== 1'b1) begin
            misses++;
            $display("FAIL busy_rise dut%0d: busy=%b in cycle 1, required 1", d, busy[d]);
          end
        end
        if (rd_en[d]) begin
          vecs++;
          if (q_rd[d].size() == 0) begin
            misses++;
            $display("FAIL read dut%0d: unexpected read addr %0d in cycle %0d", d,
                     rd_addr[d], cyc);
          end else begin
            e = q_rd[d].pop_front();
            if (e.cyc != cyc || rd_addr[d] !== AW'(e.addr)) begin
              misses++;
              $display("FAIL read dut%0d: got addr %0d in cycle %0d, required addr %0d in cycle %0d",
                       d, rd_addr[d], cyc, e.addr, e.cyc);
            end
          end
        end
        if (win_valid[d]) begin
          vecs++;
          if (q_win[d].size() == 0) begin
            misses++;
            $display("FAIL window dut%0d: unexpected window in cycle %0d", d, cyc);
          end else begin
            e = q_win[d].pop_front();
            if (e.cyc != cyc || win_pixels[d] !== e.val) begin
              misses++;
              $display("FAIL window dut%0d: got %h in cycle %0d, required %h in cycle %0d",
                       d, win_pixels[d], cyc, e.val, e.cyc);
            end
          end
        end
        if (wr_en[d]) begin
          vecs++;
          if (q_wr[d].size() == 0) begin
            misses++;
            $display("FAIL write dut%0d: unexpected write addr %0d data %0d in cycle %0d", d,
                     wr_addr[d], wr_data[d], cyc);
          end else begin
            e = q_wr[d].pop_front();
            if (e.cyc != cyc || wr_addr[d] !== AW'(e.addr) || wr_data[d] !== e.val[7:0]) begin
              misses++;
              $display("FAIL write dut%0d: got addr %0d data %0d cycle %0d, required addr %0d data %0d cycle %0d",
                       d, wr_addr[d], wr_data[d], cyc, e.addr, e.val[7:0], e.cyc);
            end
          end
        end
        if (done[d]) begin
          dseen[d]++;
          vecs++;
          if (cyc != done_cyc(d) || busy[d] !== 1'b0) begin
            misses++;
            $display("FAIL done dut%0d: done in cycle %0d with busy=%b, required cycle %0d with busy=0",
                     d, cyc, busy[d], done_cyc(d));
          end
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      vecs++;
      if (dseen[d] != 1 || q_rd[d].size() != 0 || q_win[d].size() != 0 ||
          q_wr[d].size() != 0) begin
        misses++;
        $display("FAIL frame_totals dut%0d: done=%0d left rd/win/wr=%0d/%0d/%0d, required 1 and 0/0/0",
                 d, dseen[d], q_rd[d].size(), q_win[d].size(), q_wr[d].size());
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int act [2];
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      vecs++;
      if ({busy[d], done[d], rd_en[d], rd_addr[d], win_valid[d], win_pixels[d], wr_en[d],
           wr_addr[d], wr_data[d]} !== '0) begin
        misses++;
        $display("FAIL mid_reset_outputs dut%0d: busy=%b rd_en=%b rd_addr=%0d win_valid=%b wr_en=%b wr_addr=%0d, all required 0",
                 d, busy[d], rd_en[d], rd_addr[d], win_valid[d], wr_en[d], wr_addr[d]);
      end
      act[d] = 0;
    end
    repeat (40) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rd_en[d] || win_valid[d] || wr_en[d] || busy[d] || done[d]) act[d]++;
      end
    end
    for (int d = 0; d < 2; d++) begin
      vecs++;
      if (act[d] != 0) begin
        misses++;
        $display("FAIL post_reset_quiet dut%0d: %0d active cycles, required 0", d, act[d]);
      end
    end
    test_frame(0);
  endtask

  task automatic test_ignored_requests();
    @(negedge clk) poke = 1'b1;
    @(negedge clk) poke = 1'b0;
    for (int d = 0; d < 2; d++) begin
      vecs++;
      if (wr_en[d] !== 1'b0 || busy[d] !== 1'b0) begin
        misses++;
        $display("FAIL idle_result dut%0d: wr_en=%b busy=%b, required 0 and 0", d, wr_en[d],
                 busy[d]);
      end
    end
    test_frame(7);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    poke  = 1'b0;
    test_reset();
    test_frame(0);
    test_reset_mid_frame();
    test_ignored_requests();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, misses);
    $finish;
  end

endmodule
